// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: machine word, RAM handshake state and the
// memory arbiter state encoding.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DGRANT = 2'd1,
        IGRANT = 2'd2,
        ERR    = 2'd3
    } arbstate_t;

endpackage

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between instruction fetch and data access, with
// anti-starvation for fetch, a grant timeout and a sticky error state.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int unsigned RAM_TIMEOUT  = 15,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic      CLK,
    input  logic      RST,
    input  logic      iREN,
    input  word_t     iaddr,
    input  logic      dREN,
    input  logic      dWEN,
    input  word_t     daddr,
    input  word_t     dstore,
    output logic      ihit,
    output logic      dhit,
    output word_t     iload,
    output word_t     dload,
    output logic      ramREN,
    output logic      ramWEN,
    output word_t     ramaddr,
    output word_t     ramstore,
    input  word_t     ramload,
    input  ramstate_t ramstate,
    output logic      memerr
);

    localparam int unsigned TW = ($clog2(RAM_TIMEOUT + 1) > 0) ? $clog2(RAM_TIMEOUT + 1) : 1;
    localparam int unsigned SW = ($clog2(STARVE_LIMIT + 1) > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

    arbstate_t     state_q, state_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          d_req;

    assign d_req = dREN | dWEN;

    always_comb begin
        state_d  = state_q;
        tmo_d    = tmo_q;
        starve_d = starve_q;
        unique case (state_q)
            IDLE: begin
                // Timeout restarts from zero for whichever grant follows.
                tmo_d = '0;
                if (!iREN) starve_d = '0;
                if (d_req && !(iREN && starve_q == SW'(STARVE_LIMIT)))
                    state_d = DGRANT;
                else if (iREN)
                    state_d = IGRANT;
            end
            DGRANT: begin
                if (ramstate == ERROR) begin
                    state_d = ERR;
                end else if (ramstate == ACCESS) begin
                    state_d = IDLE;
                    if (iREN && starve_q != SW'(STARVE_LIMIT))
                        starve_d = starve_q + 1'b1;
                end else if (!d_req) begin
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                    if (tmo_d == TW'(RAM_TIMEOUT)) state_d = ERR;
                end
            end
            IGRANT: begin
                if (ramstate == ERROR) begin
                    state_d = ERR;
                end else if (ramstate == ACCESS) begin
                    state_d  = IDLE;
                    starve_d = '0;
                end else if (!iREN) begin
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                    if (tmo_d == TW'(RAM_TIMEOUT)) state_d = ERR;
                end
            end
            ERR: state_d = ERR;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            tmo_q    <= '0;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            tmo_q    <= tmo_d;
            starve_q <= starve_d;
        end
    end

    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        ihit     = 1'b0;
        dhit     = 1'b0;
        iload    = '0;
        dload    = '0;
        unique case (state_q)
            DGRANT: begin
                ramaddr  = daddr;
                ramstore = dstore;
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                if (ramstate == ACCESS) begin
                    dhit  = 1'b1;
                    dload = ramload;
                end
            end
            IGRANT: begin
                ramaddr = iaddr;
                ramREN  = 1'b1;
                if (ramstate == ACCESS) begin
                    ihit  = 1'b1;
                    iload = ramload;
                end
            end
            default: ;
        endcase
    end

    assign memerr = (state_q == ERR);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: cycle-by-cycle vector table plus
// hand-built timeout, reset and starvation sequences, via a scoreboard queue.
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    localparam word_t IA = 32'h0000_1000;
    localparam word_t DA = 32'h0000_0040;
    localparam word_t DS = 32'h1234_5678;

    logic      CLK = 1'b0;
    logic      RST, iREN, dREN, dWEN;
    word_t     iaddr, daddr, dstore, ramload;
    ramstate_t ramstate;
    logic      ihit, dhit, ramREN, ramWEN, memerr;
    word_t     iload, dload, ramaddr, ramstore;

    mem_arbiter #(.RAM_TIMEOUT(15), .STARVE_LIMIT(4)) dut (
        .CLK(CLK), .RST(RST), .iREN(iREN), .iaddr(iaddr),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .ihit(ihit), .dhit(dhit), .iload(iload), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .memerr(memerr)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string     name;
        logic      rst, iren, dren, dwen;
        ramstate_t rs;
        word_t     ld;
        logic      e_rren, e_rwen, e_ihit, e_dhit, e_err;
        word_t     e_addr, e_store, e_iload, e_dload;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic vec_t mk(input string name, input logic rst, iren, dren, dwen,
                                input ramstate_t rs, input word_t ld,
                                input logic rren, rwen, ih, dh, er,
                                input word_t addr, store, il, dl);
        vec_t v;
        v.name = name; v.rst = rst; v.iren = iren; v.dren = dren; v.dwen = dwen;
        v.rs = rs; v.ld = ld;
        v.e_rren = rren; v.e_rwen = rwen; v.e_ihit = ih; v.e_dhit = dh; v.e_err = er;
        v.e_addr = addr; v.e_store = store; v.e_iload = il; v.e_dload = dl;
        return v;
    endfunction

    function automatic vec_t quiet(input string name, input logic rst, iren, dren, dwen,
                                   input ramstate_t rs, input logic er);
        return mk(name, rst, iren, dren, dwen, rs, 32'h0, 0, 0, 0, 0, er, '0, '0, '0, '0);
    endfunction

    task automatic check_now();
        vec_t e;
        e = sb.pop_front();
        n_vec++;
        if ({ramREN, ramWEN, ihit, dhit, memerr} !== {e.e_rren, e.e_rwen, e.e_ihit, e.e_dhit, e.e_err}
            || ramaddr !== e.e_addr || ramstore !== e.e_store
            || iload !== e.e_iload || dload !== e.e_dload || (ihit && dhit)) begin
            n_bad++;
            $display("FAIL %s: got ren=%b wen=%b ihit=%b dhit=%b err=%b addr=%h store=%h iload=%h dload=%h; want ren=%b wen=%b ihit=%b dhit=%b err=%b addr=%h store=%h iload=%h dload=%h",
                     e.name, ramREN, ramWEN, ihit, dhit, memerr, ramaddr, ramstore, iload, dload,
                     e.e_rren, e.e_rwen, e.e_ihit, e.e_dhit, e.e_err, e.e_addr, e.e_store, e.e_iload, e.e_dload);
        end
    endtask

    task automatic apply(input vec_t v);
        RST = v.rst; iREN = v.iren; dREN = v.dren; dWEN = v.dwen;
        ramstate = v.rs; ramload = v.ld;
        sb.push_back(v);
        @(negedge CLK);
        check_now();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1; iREN = 0; dREN = 0; dWEN = 0; ramstate = FREE; ramload = '0;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000, want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        iaddr = IA; daddr = DA; dstore = DS;
        do_reset();

        // Data read with two BUSY cycles, write-wins, flush, error, reset.
        tbl.push_back(quiet("a_req",    0, 0, 1, 0, FREE, 0));
        tbl.push_back(mk("a_busy1",     0, 0, 1, 0, BUSY,   0, 1, 0, 0, 0, 0, DA, DS, 0, 0));
        tbl.push_back(mk("a_busy2",     0, 0, 1, 0, BUSY,   0, 1, 0, 0, 0, 0, DA, DS, 0, 0));
        tbl.push_back(mk("a_access",    0, 0, 1, 0, ACCESS, 32'hDEADBEEF, 1, 0, 0, 1, 0, DA, DS, 0, 32'hDEADBEEF));
        tbl.push_back(quiet("a_idle",   0, 0, 0, 0, ACCESS, 0));
        tbl.push_back(quiet("c_req",    0, 0, 1, 1, FREE, 0));
        tbl.push_back(mk("c_busy",      0, 0, 1, 1, BUSY,   0, 0, 1, 0, 0, 0, DA, DS, 0, 0));
        tbl.push_back(mk("c_access",    0, 0, 1, 1, ACCESS, 32'h55, 0, 1, 0, 1, 0, DA, DS, 0, 32'h55));
        tbl.push_back(quiet("c_idle",   0, 0, 0, 0, FREE, 0));
        tbl.push_back(quiet("e_req",    0, 1, 1, 0, FREE, 0));
        tbl.push_back(mk("e_busy",      0, 1, 1, 0, BUSY,   0, 1, 0, 0, 0, 0, DA, DS, 0, 0));
        tbl.push_back(mk("e_flush",     0, 1, 0, 0, BUSY,   0, 0, 0, 0, 0, 0, DA, DS, 0, 0));
        tbl.push_back(quiet("e_idle",   0, 1, 0, 0, ACCESS, 0));
        tbl.push_back(mk("e_igrant",    0, 1, 0, 0, ACCESS, 32'hCAFE0001, 1, 0, 1, 0, 0, IA, 0, 32'hCAFE0001, 0));
        tbl.push_back(quiet("e_done",   0, 0, 0, 0, FREE, 0));
        tbl.push_back(quiet("x_req",    0, 0, 1, 0, FREE, 0));
        tbl.push_back(mk("x_error",     0, 0, 1, 0, ERROR,  0, 1, 0, 0, 0, 0, DA, DS, 0, 0));
        tbl.push_back(quiet("x_absorb", 0, 1, 1, 0, ACCESS, 1));
        tbl.push_back(quiet("x_rst",    1, 1, 1, 0, ACCESS, 1));
        tbl.push_back(quiet("x_clear",  0, 0, 0, 0, FREE, 0));
        foreach (tbl[i]) apply(tbl[i]);

        // Fetch stuck BUSY: 15 grant cycles, then ERR until reset.
        apply(quiet("t_req", 0, 1, 0, 0, FREE, 0));
        for (int unsigned k = 0; k < 15; k++)
            apply(mk($sformatf("t_wait%0d", k), 0, 1, 0, 0, BUSY, 0, 1, 0, 0, 0, 0, IA, 0, 0, 0));
        apply(quiet("t_err",     0, 1, 0, 0, BUSY, 1));
        apply(quiet("t_err_hold", 0, 1, 0, 0, ACCESS, 1));
        apply(quiet("t_rst",     1, 1, 0, 0, FREE, 1));
        apply(quiet("t_cleared", 0, 0, 0, 0, FREE, 0));

        // Reset in the middle of an instruction grant.
        apply(quiet("r_req", 0, 1, 0, 0, FREE, 0));
        apply(mk("r_busy",     0, 1, 0, 0, BUSY, 0, 1, 0, 0, 0, 0, IA, 0, 0, 0));
        apply(mk("r_rst",      1, 1, 0, 0, BUSY, 0, 1, 0, 0, 0, 0, IA, 0, 0, 0));
        apply(quiet("r_idle",  0, 1, 0, 0, ACCESS, 0));
        apply(mk("r_regrant",  0, 1, 0, 0, ACCESS, 32'hA5A5A5A5, 1, 0, 1, 0, 0, IA, 0, 32'hA5A5A5A5, 0));
        apply(quiet("r_done",  0, 0, 0, 0, FREE, 0));

        // Fetch and write held together: four data grants, one fetch, repeat.
        for (int unsigned c = 0; c < 20; c++) begin
            int unsigned g;
            g = c / 2;
            if (c % 2 == 0)
                apply(quiet($sformatf("s_idle%0d", c), 0, 1, 0, 1, ACCESS, 0));
            else if (g % 5 == 4)
                apply(mk($sformatf("s_ihit%0d", g), 0, 1, 0, 1, ACCESS, 32'h0BAD0000 + c,
                         1, 0, 1, 0, 0, IA, 0, 32'h0BAD0000 + c, 0));
            else
                apply(mk($sformatf("s_dhit%0d", g), 0, 1, 0, 1, ACCESS, 32'h0BAD0000 + c,
                         0, 1, 0, 1, 0, DA, DS, 0, 32'h0BAD0000 + c));
        end
        apply(quiet("s_end", 0, 0, 0, 0, FREE, 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter RAM_TIMEOUT, default 15, meaning max cycles a grant may wait for ramstate ACCESS.
REQ-002 SHALL have parameter STARVE_LIMIT, default 4, meaning max consecutive data grants completed while an instruction request waits.
REQ-003 SHALL have port CLK  in  1  system clock; the single clock domain.
REQ-004 SHALL have port RST  in  1  synchronous, active-high reset.
REQ-005 SHALL have port iREN  in  1  instruction fetch request.
REQ-006 SHALL have port iaddr  in  32 (word_t)  fetch address.
REQ-007 SHALL have ports dREN, dWEN  in  1 each  data read/write request.
REQ-008 SHALL have ports daddr, dstore  in  32 each  data address and write data.
REQ-009 SHALL have ports ihit, dhit  out  1 each  completion strobe per requester.
REQ-010 SHALL have ports iload, dload  out  32 each  read data per requester.
REQ-011 SHALL have ports ramREN, ramWEN  out  1 each  RAM enables.
REQ-012 SHALL have ports ramaddr, ramstore  out  32 each  RAM address and write data.
REQ-013 SHALL have port ramload  in  32  RAM read data.
REQ-014 SHALL have port ramstate  in  ramstate_t  FREE/BUSY/ACCESS/ERROR.
REQ-015 SHALL have port memerr  out  1  sticky error flag.

Function
REQ-016 SHALL implement a registered FSM with states IDLE, DGRANT, IGRANT, ERR.
REQ-017 IDLE: on dREN|dWEN, go to DGRANT next cycle, unless starve count == STARVE_LIMIT and iREN, then IGRANT.
REQ-018 IDLE: on iREN alone, go to IGRANT.
REQ-019 In DGRANT, ram outputs SHALL be: ramaddr=daddr, ramstore=dstore, ramWEN=dWEN, ramREN=dREN&~dWEN (write wins if both set).
REQ-020 In IGRANT, ram outputs SHALL be: ramaddr=iaddr, ramREN=1, ramWEN=0, ramstore=0.
REQ-021 In IDLE and ERR, all ram outputs SHALL be 0.
REQ-022 When ramstate==ACCESS in a grant state, the matching hit SHALL assert combinationally that cycle, with iload/dload=ramload; otherwise loads are 0.
REQ-023 Next state after an ACCESS cycle SHALL be IDLE, giving 1-cycle grant turnaround; min latency is request at cycle N -> hit at N+1.
REQ-024 If the granted requester drops its request before ACCESS (flush), the FSM SHALL return to IDLE next cycle with no hit.
REQ-025 Timeout counter SHALL clear on grant entry and increment each grant cycle without ACCESS.
REQ-026 When the timeout count reaches RAM_TIMEOUT, or ramstate==ERROR in a grant state, the FSM SHALL go to ERR.
REQ-027 ERR SHALL be absorbing until RST, with memerr=1, no hits, and ram outputs 0.
REQ-028 Starve counter SHALL increment on each DGRANT completion while iREN=1, saturate at STARVE_LIMIT, and clear on IGRANT completion or when iREN=0 in IDLE.
REQ-029 ihit and dhit SHALL never assert in the same cycle.

Reset
REQ-030 On RST at any clock edge, including mid-grant, the block SHALL enter IDLE, clear both counters and memerr, and hold all outputs at 0 in the following cycle.

Structure
REQ-031 word_t and ramstate_t SHALL come from cpu_types_pkg.
REQ-032 The arbiter state enum arbstate_t SHALL be added to cpu_types_pkg.
REQ-033 RAM_TIMEOUT and STARVE_LIMIT SHALL remain module parameters.
REQ-034 The block SHALL have no sub-module; counters and FSM are inline.

Verification
REQ-035 Bench SHALL cover: dREN=1, daddr=0x40, ramstate ACCESS after 2 BUSY cycles, ramload=0xDEADBEEF -> dhit once at cycle 3, dload=0xDEADBEEF.
REQ-036 Bench SHALL cover: iREN and dWEN held together, ACCESS every grant cycle -> 4 dhits, then 1 ihit, then the pattern repeats.
REQ-037 Bench SHALL cover: dREN=dWEN=1, dstore=0x12345678 -> ramWEN=1, ramREN=0, ramstore=0x12345678.
REQ-038 Bench SHALL cover: iREN=1, ramstate BUSY for 15 cycles -> ERR, memerr=1, ram outputs 0; then RST -> memerr=0.
REQ-039 Bench SHALL cover: dREN dropped during BUSY -> IDLE next cycle, no dhit; a pending iREN is then granted.
REQ-040 Bench SHALL cover: RST asserted mid-IGRANT -> next cycle ramREN=0, ihit=0, state IDLE.
